// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands in a FIFO, issues them one at a time and returns registered results
// Ports: clk/rst (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b/cmd_chain command in;
// alu_opcode/alu_a/alu_b to the ALU, alu_out from it; res_valid/res_ready/res_data/res_err result out; busy.
// Optional feature macro ACC_CHAIN_EN: accumulator feeding operand a for commands with cmd_chain=1.
module alu_cmd_issuer #(
  parameter int WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_chain,
  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic             busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_e;
  state_e state_q, state_d;
  logic [2:0] op_mem [FIFO_DEPTH];
  logic [WIDTH-1:0] a_mem [FIFO_DEPTH];
  logic [WIDTH-1:0] b_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic empty, full, push, pop, hs;
  logic [2:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d, head_a;
  logic valid_q, valid_d, err_q, err_d;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign cmd_ready = !rst && !full;
  assign push = cmd_valid && cmd_ready;
  assign hs = state_q == WAIT_ACK && res_ready;
  assign pop = !empty && (state_q == IDLE || hs);
`ifdef ACC_CHAIN_EN
  logic chain_mem [FIFO_DEPTH];
  logic [WIDTH-1:0] acc_q, acc_d;
  // a chained command popped on a handshake must see the result being delivered now
  assign acc_d = hs && !err_q ? data_q : acc_q;
  assign head_a = chain_mem[rd_q] ? acc_d : a_mem[rd_q];
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else acc_q <= acc_d;
  end
  always_ff @(posedge clk) begin
    if (push) chain_mem[wr_q] <= cmd_chain;
  end
`else
  logic unused_chain;
  assign unused_chain = cmd_chain;
  assign head_a = a_mem[rd_q];
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = empty ? IDLE : ISSUE;
      ISSUE:    state_d = WAIT_ACK;
      WAIT_ACK: state_d = !res_ready ? WAIT_ACK : empty ? IDLE : ISSUE;
      default:  state_d = IDLE;
    endcase
    op_d = pop ? op_mem[rd_q] : op_q;
    a_d = pop ? head_a : a_q;
    b_d = pop ? b_mem[rd_q] : b_q;
    data_d = state_q == ISSUE ? (op_q > 3'd4 ? '0 : alu_out) : data_q;
    err_d = state_q == ISSUE ? op_q > 3'd4 : err_q;
    valid_d = state_q == ISSUE ? 1'b1 : hs ? 1'b0 : valid_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_q + AW'(push);
      rd_q <= rd_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      data_q <= data_d;
      err_q <= err_d;
      valid_q <= valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_q] <= cmd_op;
      a_mem[wr_q] <= cmd_a;
      b_mem[wr_q] <= cmd_b;
    end
  end
  assign alu_opcode = op_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign res_valid = valid_q;
  assign res_data = data_q;
  assign res_err = err_q;
  assign busy = state_q != IDLE || !empty;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed vector bench for alu_cmd_issuer with a behavioural ALU attached
module tb_alu_cmd_issuer;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_ready, cmd_chain = 0;
  logic [2:0] cmd_op = 0, alu_opcode;
  logic [7:0] cmd_a = 0, cmd_b = 0, alu_a, alu_b, alu_out, res_data;
  logic res_valid, res_ready = 0, res_err, busy;
  int n_chk = 0, n_fail = 0;
  typedef struct { logic [2:0] op; logic [7:0] a; logic [7:0] b; logic [7:0] d; logic e; } vec_t;
  vec_t vecs [10];
  always #5 clk = ~clk;
  always_comb begin
    case (alu_opcode)
      3'd0: alu_out = alu_a + alu_b;
      3'd1: alu_out = alu_a - alu_b;
      3'd2: alu_out = alu_a & alu_b;
      3'd3: alu_out = alu_a | alu_b;
      3'd4: alu_out = ~alu_a;
      default: alu_out = alu_a ^ 8'h5A;
    endcase
  end
  alu_cmd_issuer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain), .alu_opcode(alu_opcode), .alu_a(alu_a),
    .alu_b(alu_b), .alu_out(alu_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err), .busy(busy)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic ch);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    cmd_chain = ch;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL push: cmd_ready never rose (timeout)");
    end
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask
  task automatic expect_result(input string name, input logic [7:0] d, input logic e);
    int n = 0;
    @(negedge clk);
    while (!res_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: res_valid never rose (timeout)", name);
    end else begin
      check({name, " data"}, res_data, d);
      check({name, " err"}, res_err, e);
    end
    res_ready = 1;
    @(posedge clk);
    #1 res_ready = 0;
  endtask
  initial begin
    int seen;
    vecs[0] = '{3'd1, 8'h00, 8'h01, 8'hFF, 1'b0};
    vecs[1] = '{3'd4, 8'hA5, 8'h00, 8'h5A, 1'b0};
    vecs[2] = '{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[3] = '{3'd3, 8'hF0, 8'h3C, 8'hFC, 1'b0};
    vecs[4] = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b0};
    vecs[5] = '{3'd1, 8'h05, 8'h07, 8'hFE, 1'b0};
    vecs[6] = '{3'd6, 8'h12, 8'h00, 8'h00, 1'b1};
    vecs[7] = '{3'd0, 8'h01, 8'h01, 8'h02, 1'b0};
    vecs[8] = '{3'd5, 8'h33, 8'h44, 8'h00, 1'b1};
    vecs[9] = '{3'd7, 8'h80, 8'h01, 8'h00, 1'b1};
    repeat (3) @(negedge clk);
    check("rst cmd_ready", cmd_ready, 0);
    check("rst res_valid", res_valid, 0);
    check("rst res_err", res_err, 0);
    check("rst res_data", res_data, 0);
    check("rst busy", busy, 0);
    check("rst alu_opcode", alu_opcode, 0);
    check("rst alu_a", alu_a, 0);
    check("rst alu_b", alu_b, 0);
    rst = 0;
    @(negedge clk);
    check("post-rst cmd_ready", cmd_ready, 1);
    res_ready = 1;
    push(3'd0, 8'h0F, 8'h01, 1'b0);
    @(negedge clk);
    check("T1 E0 res_valid", res_valid, 0);
    check("T1 E0 busy", busy, 1);
    @(negedge clk);
    check("T1 E1 alu_a", alu_a, 8'h0F);
    check("T1 E1 alu_b", alu_b, 8'h01);
    check("T1 E1 alu_opcode", alu_opcode, 0);
    check("T1 E1 res_valid", res_valid, 0);
    @(negedge clk);
    check("T1 E2 res_valid", res_valid, 1);
    check("T1 E2 res_data", res_data, 8'h10);
    check("T1 E2 res_err", res_err, 0);
    @(negedge clk);
    check("T1 after ack res_valid", res_valid, 0);
    check("T1 after ack busy", busy, 0);
    check("T1 alu_a held", alu_a, 8'h0F);
    res_ready = 0;
    for (int i = 0; i < 10; i++) begin
      push(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      expect_result($sformatf("vec%0d", i), vecs[i].d, vecs[i].e);
    end
    for (int i = 0; i < 5; i++) push(3'd0, 8'(i), 8'h10, 1'b0);
    @(negedge clk);
    check("T3 full cmd_ready", cmd_ready, 0);
    check("T3 res_valid", res_valid, 1);
    check("T3 busy", busy, 1);
    for (int i = 0; i < 5; i++) expect_result($sformatf("T3 res%0d", i), 8'h10 + 8'(i), 1'b0);
    push(3'd0, 8'h01, 8'h01, 1'b0);
    push(3'd0, 8'h02, 8'h02, 1'b0);
    push(3'd0, 8'h03, 8'h03, 1'b0);
    @(negedge clk);
    check("T5 pre res_valid", res_valid, 1);
    rst = 1;
    #1 check("T5 rst cmd_ready", cmd_ready, 0);
    @(negedge clk);
    check("T5 res_valid", res_valid, 0);
    check("T5 busy", busy, 0);
    rst = 0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid || busy) seen++;
    end
    check("T5 no stale activity", seen, 0);
    push(3'd0, 8'h02, 8'h03, 1'b0);
    expect_result("T5 fresh", 8'h05, 1'b0);
`ifdef ACC_CHAIN_EN
    push(3'd0, 8'h03, 8'h04, 1'b0);
    push(3'd0, 8'hAA, 8'h05, 1'b1);
    expect_result("T6 add", 8'h07, 1'b0);
    expect_result("T6 chain add", 8'h0C, 1'b0);
    push(3'd1, 8'hAA, 8'h0D, 1'b1);
    expect_result("T6 chain minus", 8'hFF, 1'b0);
    push(3'd6, 8'h12, 8'h00, 1'b0);
    expect_result("T6 illegal", 8'h00, 1'b1);
    push(3'd0, 8'h55, 8'h01, 1'b1);
    expect_result("T6 acc kept", 8'h00, 1'b0);
`else
    push(3'd0, 8'h03, 8'h04, 1'b1);
    expect_result("chain ignored 1", 8'h07, 1'b0);
    push(3'd0, 8'h01, 8'h01, 1'b1);
    expect_result("chain ignored 2", 8'h02, 1'b0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
